// File: rtl/bp_nonsynth_retire_aligner.sv
// bp_nonsynth_retire_aligner: pairs committed instructions with their rd writebacks
// and emits one in-order retire record per instruction, flagging protocol anomalies.
module bp_nonsynth_retire_aligner #(
    parameter int vaddr_width_p    = 39,
    parameter int instr_width_p    = 32,
    parameter int dword_width_p    = 64,
    parameter int reg_addr_width_p = 5,
    parameter int els_p            = 8,
    parameter int timeout_p        = 1023
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        freeze_i,
    input  logic                        commit_v_i,
    input  logic [vaddr_width_p-1:0]    commit_pc_i,
    input  logic [instr_width_p-1:0]    commit_instr_i,
    input  logic                        commit_wb_i,
    output logic                        commit_ready_o,
    input  logic                        int_rd_w_v_i,
    input  logic [reg_addr_width_p-1:0] int_rd_addr_i,
    input  logic [dword_width_p-1:0]    int_rd_data_i,
    input  logic                        fp_rd_w_v_i,
    input  logic [reg_addr_width_p-1:0] fp_rd_addr_i,
    input  logic [dword_width_p-1:0]    fp_rd_data_i,
    output logic                        retire_v_o,
    input  logic                        retire_ready_i,
    output logic [vaddr_width_p-1:0]    retire_pc_o,
    output logic [instr_width_p-1:0]    retire_instr_o,
    output logic [29:0]                 retire_itag_o,
    output logic                        retire_rd_v_o,
    output logic                        retire_rd_fp_o,
    output logic [reg_addr_width_p-1:0] retire_rd_addr_o,
    output logic [dword_width_p-1:0]    retire_rd_data_o,
    output logic                        overflow_o,
    output logic                        stray_wb_o,
    output logic                        wb_conflict_o,
    output logic                        timeout_o
);
    localparam int ptr_w = $clog2(els_p);
    localparam int tmr_w = $clog2(timeout_p + 1);

    logic [vaddr_width_p-1:0]    c_pc    [els_p];
    logic [instr_width_p-1:0]    c_instr [els_p];
    logic [29:0]                 c_itag  [els_p];
    logic [els_p-1:0]            c_wb;
    logic [els_p-1:0]            w_fp;
    logic [reg_addr_width_p-1:0] w_addr  [els_p];
    logic [dword_width_p-1:0]    w_data  [els_p];
    logic [ptr_w:0]              c_wr, c_rd, w_wr, w_rd, owed, owed_eff;
    logic [29:0]                 itag;
    logic [tmr_w-1:0]            timer;
    logic [ptr_w-1:0]            c_head, w_head;
    logic                        c_empty, c_full, w_empty, head_wb;
    logic                        c_enq, wb_any, w_enq, pop, w_pop, waiting;
    logic                        wb_fp;
    logic [reg_addr_width_p-1:0] wb_addr;
    logic [dword_width_p-1:0]    wb_data;

    assign c_head   = c_rd[ptr_w-1:0];
    assign w_head   = w_rd[ptr_w-1:0];
    assign c_empty  = c_wr == c_rd;
    assign c_full   = (c_wr[ptr_w] != c_rd[ptr_w]) & (c_wr[ptr_w-1:0] == c_rd[ptr_w-1:0]);
    assign w_empty  = w_wr == w_rd;
    assign head_wb  = c_wb[c_head];

    assign c_enq    = commit_v_i & ~freeze_i & ~c_full;
    assign wb_any   = (int_rd_w_v_i | fp_rd_w_v_i) & ~freeze_i;
    // int wins a same-cycle int/fp collision
    assign wb_fp    = ~int_rd_w_v_i;
    assign wb_addr  = int_rd_w_v_i ? int_rd_addr_i : fp_rd_addr_i;
    assign wb_data  = int_rd_w_v_i ? int_rd_data_i : fp_rd_data_i;
    assign owed_eff = owed + (ptr_w+1)'(c_enq & commit_wb_i);
    assign w_enq    = wb_any & (owed_eff != '0);

    assign retire_v_o = ~c_empty & (~head_wb | ~w_empty);
    assign pop        = retire_v_o & retire_ready_i;
    assign w_pop      = pop & head_wb;
    assign waiting    = ~c_empty & head_wb & w_empty;

    assign commit_ready_o   = ~c_full;
    assign retire_pc_o      = c_pc[c_head];
    assign retire_instr_o   = c_instr[c_head];
    assign retire_itag_o    = c_itag[c_head];
    assign retire_rd_v_o    = retire_v_o & head_wb;
    assign retire_rd_fp_o   = retire_rd_v_o & w_fp[w_head];
    assign retire_rd_addr_o = retire_rd_v_o ? w_addr[w_head] : '0;
    assign retire_rd_data_o = retire_rd_v_o ? w_data[w_head] : '0;

    always_ff @(posedge clk_i) begin
        if (c_enq) begin
            c_pc[c_wr[ptr_w-1:0]]    <= commit_pc_i;
            c_instr[c_wr[ptr_w-1:0]] <= commit_instr_i;
            c_itag[c_wr[ptr_w-1:0]]  <= itag;
            c_wb[c_wr[ptr_w-1:0]]    <= commit_wb_i;
        end
        if (w_enq) begin
            w_fp[w_wr[ptr_w-1:0]]   <= wb_fp;
            w_addr[w_wr[ptr_w-1:0]] <= wb_addr;
            w_data[w_wr[ptr_w-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            c_wr          <= '0;
            c_rd          <= '0;
            w_wr          <= '0;
            w_rd          <= '0;
            itag          <= '0;
            owed          <= '0;
            timer         <= '0;
            overflow_o    <= 1'b0;
            stray_wb_o    <= 1'b0;
            wb_conflict_o <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            c_wr          <= c_wr + (ptr_w+1)'(c_enq);
            itag          <= itag + 30'(c_enq);
            c_rd          <= c_rd + (ptr_w+1)'(pop);
            w_wr          <= w_wr + (ptr_w+1)'(w_enq);
            w_rd          <= w_rd + (ptr_w+1)'(w_pop);
            owed          <= owed_eff - (ptr_w+1)'(w_enq);
            timer         <= (pop | w_enq) ? '0 :
                             (waiting & timer != tmr_w'(timeout_p)) ? timer + 1'b1 : timer;
            overflow_o    <= overflow_o | (commit_v_i & ~freeze_i & c_full);
            stray_wb_o    <= stray_wb_o | (wb_any & owed_eff == '0);
            wb_conflict_o <= wb_conflict_o | (int_rd_w_v_i & fp_rd_w_v_i & ~freeze_i);
            timeout_o     <= timeout_o | (waiting & ~(pop | w_enq) & timer == tmr_w'(timeout_p - 1));
        end
    end
endmodule

// File: tb/tb_bp_nonsynth_retire_aligner.sv
// tb_bp_nonsynth_retire_aligner: directed + random stimulus checked every cycle
// against a queue-based reference model of the retire aligner.
module tb_bp_nonsynth_retire_aligner;
    localparam int ELS = 8;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset_n_i, freeze_i, commit_v_i, commit_wb_i, commit_ready_o;
    logic [38:0] commit_pc_i;
    logic [31:0] commit_instr_i;
    logic        int_rd_w_v_i, fp_rd_w_v_i;
    logic [4:0]  int_rd_addr_i, fp_rd_addr_i;
    logic [63:0] int_rd_data_i, fp_rd_data_i;
    logic        retire_v_o, retire_ready_i, retire_rd_v_o, retire_rd_fp_o;
    logic [38:0] retire_pc_o;
    logic [31:0] retire_instr_o;
    logic [29:0] retire_itag_o;
    logic [4:0]  retire_rd_addr_o;
    logic [63:0] retire_rd_data_o;
    logic        overflow_o, stray_wb_o, wb_conflict_o, timeout_o;

    bp_nonsynth_retire_aligner #(.els_p(ELS), .timeout_p(TMO)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .freeze_i(freeze_i),
        .commit_v_i(commit_v_i), .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i),
        .commit_wb_i(commit_wb_i), .commit_ready_o(commit_ready_o),
        .int_rd_w_v_i(int_rd_w_v_i), .int_rd_addr_i(int_rd_addr_i), .int_rd_data_i(int_rd_data_i),
        .fp_rd_w_v_i(fp_rd_w_v_i), .fp_rd_addr_i(fp_rd_addr_i), .fp_rd_data_i(fp_rd_data_i),
        .retire_v_o(retire_v_o), .retire_ready_i(retire_ready_i), .retire_pc_o(retire_pc_o),
        .retire_instr_o(retire_instr_o), .retire_itag_o(retire_itag_o),
        .retire_rd_v_o(retire_rd_v_o), .retire_rd_fp_o(retire_rd_fp_o),
        .retire_rd_addr_o(retire_rd_addr_o), .retire_rd_data_o(retire_rd_data_o),
        .overflow_o(overflow_o), .stray_wb_o(stray_wb_o), .wb_conflict_o(wb_conflict_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [38:0] pc;
        logic [31:0] instr;
        bit          wb;
        logic [29:0] itag;
    } crec_t;
    typedef struct {
        bit          fp;
        logic [4:0]  addr;
        logic [63:0] data;
    } wrec_t;

    crec_t       cq[$];
    wrec_t       wq[$];
    int          owed, wait_cnt;
    logic [29:0] m_itag;
    bit          m_ovf, m_stray, m_conf, m_tmo;
    int          errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cq.delete();
        wq.delete();
        owed = 0;
        wait_cnt = 0;
        m_itag = '0;
        {m_ovf, m_stray, m_conf, m_tmo} = '0;
    endtask

    task automatic idle();
        commit_v_i = 0; commit_wb_i = 0; int_rd_w_v_i = 0; fp_rd_w_v_i = 0; freeze_i = 0;
    endtask

    // Check outputs at negedge, then advance the model by the cycle's inputs.
    task automatic cyc();
        bit    mv, pop, full, got, waiting;
        crec_t c;
        wrec_t w;
        @(negedge clk);
        mv = cq.size() != 0 && (!cq[0].wb || wq.size() != 0);
        chk("retire_v", retire_v_o, mv);
        chk("commit_ready", commit_ready_o, cq.size() < ELS);
        chk("overflow", overflow_o, m_ovf);
        chk("stray_wb", stray_wb_o, m_stray);
        chk("wb_conflict", wb_conflict_o, m_conf);
        chk("timeout", timeout_o, m_tmo);
        if (mv) begin
            chk("pc", retire_pc_o, cq[0].pc);
            chk("instr", retire_instr_o, cq[0].instr);
            chk("itag", retire_itag_o, cq[0].itag);
            chk("rd_v", retire_rd_v_o, cq[0].wb);
            chk("rd_fp", retire_rd_fp_o, cq[0].wb ? wq[0].fp : 1'b0);
            chk("rd_addr", retire_rd_addr_o, cq[0].wb ? wq[0].addr : 5'd0);
            chk("rd_data", retire_rd_data_o, cq[0].wb ? wq[0].data : 64'd0);
        end
        waiting = cq.size() != 0 && cq[0].wb && wq.size() == 0;
        full = cq.size() == ELS;
        pop = mv && retire_ready_i;
        got = 0;
        if (!freeze_i && commit_v_i) begin
            if (full) m_ovf = 1;
            else begin
                c.pc = commit_pc_i; c.instr = commit_instr_i; c.wb = commit_wb_i; c.itag = m_itag;
                cq.push_back(c);
                m_itag++;
                if (commit_wb_i) owed++;
            end
        end
        if (!freeze_i && (int_rd_w_v_i || fp_rd_w_v_i)) begin
            if (int_rd_w_v_i && fp_rd_w_v_i) m_conf = 1;
            if (owed == 0) m_stray = 1;
            else begin
                w.fp = !int_rd_w_v_i;
                w.addr = int_rd_w_v_i ? int_rd_addr_i : fp_rd_addr_i;
                w.data = int_rd_w_v_i ? int_rd_data_i : fp_rd_data_i;
                wq.push_back(w);
                owed--;
                got = 1;
            end
        end
        if (pop) begin
            if (cq[0].wb) void'(wq.pop_front());
            void'(cq.pop_front());
        end
        if (pop || got) wait_cnt = 0;
        else if (waiting) begin
            wait_cnt++;
            if (wait_cnt >= TMO) m_tmo = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [38:0] pc, input logic [31:0] instr, input bit wb);
        commit_v_i = 1; commit_pc_i = pc; commit_instr_i = instr; commit_wb_i = wb;
    endtask

    task automatic do_reset();
        idle();
        reset_n_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n_i = 1;
    endtask

    initial begin
        retire_ready_i = 1; commit_pc_i = '0; commit_instr_i = '0;
        int_rd_addr_i = '0; int_rd_data_i = '0; fp_rd_addr_i = '0; fp_rd_data_i = '0;
        do_reset();
        chk("reset_retire_v", retire_v_o, 0);
        chk("reset_commit_ready", commit_ready_o, 1);
        cyc();

        // 1: no-writeback commit retires next cycle
        commit(39'h80000000, 32'h00000013, 0);
        cyc();
        idle();
        chk("t1_v", retire_v_o, 1);
        chk("t1_itag", retire_itag_o, 0);
        chk("t1_rd_v", retire_rd_v_o, 0);
        cyc();

        // 2: writeback arrives 5 cycles after commit
        commit(39'h80000004, 32'h00500293, 1);
        cyc();
        idle();
        repeat (5) cyc();
        int_rd_w_v_i = 1; int_rd_addr_i = 5; int_rd_data_i = 64'hdead;
        cyc();
        idle();
        chk("t2_v", retire_v_o, 1);
        chk("t2_addr", retire_rd_addr_o, 5);
        chk("t2_data", retire_rd_data_o, 64'hdead);
        cyc();

        // 3: overflow with consumer stalled, then drain
        retire_ready_i = 0;
        for (int i = 0; i < 9; i++) begin
            commit(39'h80001000 + 39'(4 * i), 32'(i), 0);
            cyc();
        end
        idle();
        chk("t3_ready", commit_ready_o, 0);
        chk("t3_ovf", overflow_o, 1);
        retire_ready_i = 1;
        repeat (10) cyc();

        // 4: stray writeback, then int/fp collision
        int_rd_w_v_i = 1; int_rd_addr_i = 7; int_rd_data_i = 64'h1;
        cyc();
        idle();
        chk("t4_stray", stray_wb_o, 1);
        chk("t4_no_rec", retire_v_o, 0);
        int_rd_w_v_i = 1; fp_rd_w_v_i = 1;
        cyc();
        idle();
        chk("t4_conflict", wb_conflict_o, 1);

        // 5: head starves for a writeback until timeout, then still retires
        commit(39'h80002000, 32'h00000053, 1);
        cyc();
        idle();
        repeat (10) cyc();
        chk("t5_early", timeout_o, 0);
        repeat (10) cyc();
        chk("t5_tmo", timeout_o, 1);
        fp_rd_w_v_i = 1; fp_rd_addr_i = 3; fp_rd_data_i = 64'h3ff0000000000000;
        cyc();
        idle();
        chk("t5_fp", retire_rd_fp_o, 1);
        cyc();

        // 6: async reset with records queued
        retire_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            commit(39'h80003000 + 39'(4 * i), 32'h13, 0);
            cyc();
        end
        idle();
        chk("t6_queued", retire_v_o, 1);
        #2;
        reset_n_i = 0;
        #1;
        chk("t6_async", retire_v_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n_i = 1;
        retire_ready_i = 1;
        commit(39'h80004000, 32'h13, 0);
        cyc();
        idle();
        chk("t6_itag", retire_itag_o, 0);
        cyc();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            commit_v_i = ($urandom_range(2) == 0);
            commit_wb_i = $urandom_range(1);
            commit_pc_i = {$urandom, $urandom};
            commit_instr_i = $urandom;
            int_rd_w_v_i = ($urandom_range(2) == 0);
            int_rd_addr_i = 5'($urandom);
            int_rd_data_i = {$urandom, $urandom};
            fp_rd_w_v_i = ($urandom_range(7) == 0);
            fp_rd_addr_i = 5'($urandom);
            fp_rd_data_i = {$urandom, $urandom};
            freeze_i = ($urandom_range(9) == 0);
            retire_ready_i = ($urandom_range(3) != 0);
            cyc();
        end
        idle();
        retire_ready_i = 1;
        repeat (5) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
